// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// FSM state codes and the datapath select encodings driven by the controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_JR       = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [2:0] MEMTOREG_ALUOUT = 3'b000;
    localparam logic [2:0] MEMTOREG_MDR    = 3'b001;
    localparam logic [2:0] MEMTOREG_PC     = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/mc_dispatch.sv
// DECODE dispatch: maps opcode/funct to the first execution state, and flags
// opcodes the controller does not implement.
module mc_dispatch
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     target,
    output logic       illegal
);

    always_comb begin
        target  = S_FETCH;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE:         target = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW:     target = S_MEM_ADDR;
            OP_BEQ, OP_BNE:   target = S_BRANCH;
            OP_ADDI, OP_ANDI: target = S_EXEC_I;
            OP_J, OP_JAL:     target = S_JUMP;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM; outputs decode combinationally from state/opcode.
// Optional macro MC_WAIT_EN adds memory wait states driven by mem_ready.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNot,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [2:0] MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t cur_state;
    state_t next_state;
    state_t dispatch_target;
    logic   dispatch_illegal;
    logic   mem_ok;

    // Memory handshake: the request (MemRead/MemWrite with IorD) is held in its
    // state; the access completes on a rising edge where mem_ok is 1.
`ifdef MC_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    mc_dispatch u_dispatch (
        .opcode  (opcode),
        .funct   (funct),
        .target  (dispatch_target),
        .illegal (dispatch_illegal)
    );

    assign state = cur_state;

    always_comb begin
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:    next_state = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE:   next_state = dispatch_target;
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD :
                                     (opcode == OP_SW) ? S_MEM_WR : S_FETCH;
            S_MEM_RD:   next_state = mem_ok ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   next_state = mem_ok ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   next_state = S_ALU_WB;
            S_EXEC_I:   next_state = S_ALU_WB;
            default:    next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (cur_state == S_DECODE && dispatch_illegal)
                illegal_op <= 1'b1;
        end
    end

    always_comb begin
        PCWrite        = 1'b0;
        PCWriteCond    = 1'b0;
        PCWriteCondNot = 1'b0;
        IorD           = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IRWrite        = 1'b0;
        RegWrite       = 1'b0;
        ALUSrcA        = 1'b0;
        RegDst         = REGDST_RT;
        MemToReg       = MEMTOREG_ALUOUT;
        ALUSrcB        = SRCB_B;
        ALUOp          = ALUOP_ADD;
        PCSource       = PCSRC_ALU;
        instr_done     = 1'b0;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ok;
                ALUSrcB = SRCB_FOUR;
                PCWrite = mem_ok;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                instr_done = dispatch_illegal;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                RegDst     = REGDST_RT;
                MemToReg   = MEMTOREG_MDR;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ok;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = (opcode == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
            end
            S_ALU_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = MEMTOREG_ALUOUT;
                RegDst     = (opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA        = 1'b1;
                ALUOp          = ALUOP_SUB;
                PCSource       = PCSRC_ALUOUT;
                PCWriteCond    = (opcode == OP_BEQ);
                PCWriteCondNot = (opcode == OP_BNE);
                instr_done     = 1'b1;
            end
            S_JUMP: begin
                PCSource   = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_RA;
                    MemToReg = MEMTOREG_PC;
                end
            end
            S_JR: begin
                PCSource   = PCSRC_RS;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons the current instruction: no architectural write may land.
        if (rst) begin
            PCWrite        = 1'b0;
            PCWriteCond    = 1'b0;
            PCWriteCondNot = 1'b0;
            IRWrite        = 1'b0;
            RegWrite       = 1'b0;
            MemWrite       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level model
// (state sequence per instruction class, per-state control table, latency table).
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCWriteCondNot, IorD, MemRead, MemWrite;
    logic       IRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst;
    logic [2:0] MemToReg;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    logic [19:0] ctrl_obs;
    int          total = 0;
    int          bad = 0;
    logic        ill_model;
    logic [3:0]  exp_q[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNot(PCWriteCondNot),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    assign ctrl_obs = {PCWrite, PCWriteCond, PCWriteCondNot, IorD, MemRead, MemWrite,
                       IRWrite, RegWrite, ALUSrcA, RegDst, MemToReg, ALUSrcB, ALUOp, PCSource};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control values each state must present, straight from the state table.
    function automatic logic [19:0] exp_ctrl(input int st, input logic [5:0] op, input logic in_rst);
        logic pcw, pcwc, pcwcn, iord, mrd, mwr, irw, rw, srca;
        logic [1:0] rdst, srcb, aluop, pcsrc;
        logic [2:0] m2r;
        {pcw, pcwc, pcwcn, iord, mrd, mwr, irw, rw, srca} = '0;
        rdst = 2'd0; srcb = 2'd0; aluop = 2'd0; pcsrc = 2'd0; m2r = 3'd0;
        case (st)
            0:  begin mrd = 1; irw = 1; srcb = 2'd1; pcw = 1; end
            1:  srcb = 2'd3;
            2:  begin srca = 1; srcb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 3'd1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aluop = 2'd2; end
            7:  begin rw = 1; rdst = (op == 6'd0) ? 2'd1 : 2'd0; end
            8:  begin srca = 1; aluop = 2'd1; pcsrc = 2'd1;
                      pcwc = (op == 6'b000100); pcwcn = (op == 6'b000101); end
            9:  begin pcsrc = 2'd2; pcw = 1;
                      if (op == 6'b000011) begin rw = 1; rdst = 2'd2; m2r = 3'd2; end end
            10: begin srca = 1; srcb = 2'd2; aluop = (op == 6'b001100) ? 2'd3 : 2'd0; end
            11: begin pcsrc = 2'd3; pcw = 1; end
            default: ;
        endcase
        if (in_rst) begin pcw = 0; pcwc = 0; pcwcn = 0; irw = 0; rw = 0; mwr = 0; end
        return {pcw, pcwc, pcwcn, iord, mrd, mwr, irw, rw, srca, rdst, m2r, srcb, aluop, pcsrc};
    endfunction

    function automatic int latency(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011:                       return 5;
            6'b101011, 6'b001000, 6'b001100: return 4;
            6'b000000:                       return (fn == 6'b001000) ? 3 : 4;
            6'b000100, 6'b000101, 6'b000010, 6'b000011: return 3;
            default:                         return 2;
        endcase
    endfunction

    task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
        exp_q.delete();
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        case (op)
            6'b100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
            6'b101011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
            6'b000000: begin
                if (fn == 6'b001000) exp_q.push_back(4'd11);
                else begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
            end
            6'b001000, 6'b001100: begin exp_q.push_back(4'd10); exp_q.push_back(4'd7); end
            6'b000100, 6'b000101: exp_q.push_back(4'd8);
            6'b000010, 6'b000011: exp_q.push_back(4'd9);
            default: ;
        endcase
    endtask

    // Runs one instruction from FETCH; abort_at >= 0 raises rst in that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
        int n = 0;
        int done_at = -1;
        logic [3:0] st;
        logic is_illegal;
        build_seq(op, fn);
        is_illegal = (exp_q.size() == 2);
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        while (exp_q.size() > 0) begin
            st = exp_q.pop_front();
            if (n == 1) begin opcode = op; funct = fn; end
            if (n == abort_at) rst = 1'b1;
`ifndef MC_WAIT_EN
            mem_ready = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            check("state", 32'(state), 32'(st));
            check("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(int'(st), op, rst)));
            check("illegal_op", 32'(illegal_op), 32'(ill_model));
            if (!rst) check("instr_done", 32'(instr_done), 32'(exp_q.size() == 0));
            if (instr_done && done_at < 0) done_at = n + 1;
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                ill_model = 1'b0;
                exp_q.delete();
                return;
            end
            if (is_illegal && n == 1) ill_model = 1'b1;
            n++;
        end
        check("latency", 32'(done_at), 32'(latency(op, fn)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(0, 6'd0, 1'b1)));
        @(posedge clk);
        #1;
        rst = 1'b0;
        ill_model = 1'b0;
    endtask

`ifdef MC_WAIT_EN
    task automatic run_sw_wait();
        int mw_cnt = 0;
        int done_cnt = 0;
        mem_ready = 1'b1;
        opcode = 6'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_state", 32'(state), 32'(i));
            @(posedge clk);
            #1;
            if (i == 0) opcode = 6'b101011;
        end
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            check("wait_memwr_state", 32'(state), 32'd5);
            check("wait_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(5, 6'b101011, 1'b0)));
            check("wait_done", 32'(instr_done), 32'(i == 3));
            mw_cnt += int'(MemWrite);
            done_cnt += int'(instr_done);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        check("wait_memwrite_cycles", 32'(mw_cnt), 32'd4);
        check("wait_done_pulses", 32'(done_cnt), 32'd1);
    endtask
`endif

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                          6'b001000, 6'b001100, 6'b100011, 6'b101011};
    endfunction

    initial begin
        logic [5:0] ops[9];
        logic [5:0] op, fn;
        int len;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
                6'b000100, 6'b000101, 6'b000010, 6'b000011};
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; ill_model = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(0, 6'd0, 1'b1)));
        check("reset_illegal", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(6'b100011, 6'd5, -1);        // LW
        run_instr(6'b000101, 6'd0, -1);        // BNE
        run_instr(6'b000011, 6'd0, -1);        // JAL
        run_instr(6'b000000, 6'b001000, -1);   // JR
        run_instr(6'b111111, 6'd0, -1);        // illegal
        run_instr(6'b001000, 6'd0, -1);        // ADDI with sticky flag set
        do_reset();
        run_instr(6'b000000, 6'b100000, 2);    // abort in EXEC_R
        run_instr(6'b000000, 6'b100100, 3);    // abort in ALU_WB
        run_instr(6'b001100, 6'd0, -1);
`ifdef MC_WAIT_EN
        run_sw_wait();
        run_instr(6'b000100, 6'd0, -1);
`endif
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = ops[$urandom_range(0, 8)];
            end
            fn = 6'($urandom);
            if (op == 6'b000000 && $urandom_range(0, 2) == 0) fn = 6'b001000;
            len = latency(op, fn);
            run_instr(op, fn, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
